hdlc_tx_ctrl: RTL and testbench
===============================

HDLC_TX_CTRL -- requirements
Module: hdlc_tx_ctrl

Interface
REQ-001 Parameter MAX_BYTES, default 128, maximum frame payload in bytes.
REQ-002 Clk  in  1  single system clock; all state updates on posedge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 Tx_Enable  in  1  start-of-frame request, sampled each cycle.
REQ-005 Tx_FrameSize  in  8  payload byte count, sampled with Tx_Enable; valid range 1..MAX_BYTES.
REQ-006 Tx_Data  in  8  buffer byte, valid the cycle after Tx_RdBuff and held until the next Tx_RdBuff.
REQ-007 Tx_AbortFrame  in  1  abort request.
REQ-008 Tx_RdBuff  out  1  one-cycle pop strobe to the Tx buffer.
REQ-009 Tx  out  1  registered serial line, LSB first.
REQ-010 Tx_ValidFrame  out  1  high while a frame (flags, data or abort pattern) is on Tx.
REQ-011 Tx_AbortedTrans  out  1  sticky abort-completed status.

Function
REQ-012 States: IDLE, START_FLAG, DATA, END_FLAG, ABORT; 3-bit bit counter, 8-bit byte counter, 3-bit ones counter.
REQ-013 IDLE shall drive Tx=1 continuously (idle pattern).
REQ-014 Tx_Enable in IDLE with size 1..MAX_BYTES shall be accepted at edge t: size latched, first flag bit on Tx and Tx_ValidFrame=1 from t+1.
REQ-015 Tx_Enable outside IDLE, or with size 0 or >MAX_BYTES, shall be ignored with no output change.
REQ-016 START_FLAG/END_FLAG shall emit 0x7E LSB first (0,1,1,1,1,1,1,0), 8 cycles each, no stuffing.
REQ-017 Tx_RdBuff shall pulse once per payload byte, during the cycle bit index 6 of the preceding flag/byte is on Tx; Tx_Data captured into the shift register at the end of the following cycle.
REQ-018 DATA shall emit each byte LSB first; after five consecutive data 1s a 0 shall be inserted (one extra cycle) and the ones counter cleared; counting continues across byte boundaries and is cleared at each flag.
REQ-019 After the last byte and any pending stuffed 0, END_FLAG follows immediately; then Tx_ValidFrame=0, state IDLE, Tx=1.
REQ-020 Exactly Tx_FrameSize Tx_RdBuff pulses per completed frame.
REQ-021 Tx_AbortFrame in START_FLAG or DATA: from the next cycle Tx shall emit 0 then seven 1s (0xFE LSB first), no further Tx_RdBuff, then IDLE with Tx_ValidFrame=0.
REQ-022 Tx_AbortFrame in IDLE, END_FLAG or ABORT shall be ignored.
REQ-023 Tx_AbortedTrans shall set in the cycle the abort pattern ends, clear on the next accepted Tx_Enable.
REQ-024 Tx_Enable and Tx_AbortFrame together in IDLE: enable accepted, abort ignored.

Reset
REQ-025 Rst shall force IDLE, Tx=1, Tx_ValidFrame=0, Tx_RdBuff=0, Tx_AbortedTrans=0, all counters 0, immediately and asynchronously.
REQ-026 Reset mid-frame shall discard the frame; no further Tx_RdBuff until a new accepted Tx_Enable.

Structure
REQ-027 Package hdlc_pkg shall hold the state enum, FLAG_BYTE=8'h7E, ABORT_BYTE=8'hFE, STUFF_LIMIT=5.
REQ-028 Zero-insertion ones counter and stuff decision shall be sub-module hdlc_tx_stuffer; FSM, counters and shift register stay in hdlc_tx_ctrl.

Verification
REQ-029 Size 1, data 0x00 -> Tx 01111110 00000000 01111110, Tx_ValidFrame high 24 cycles, one Tx_RdBuff.
REQ-030 Size 1, data 0xFF -> data field 111110111 (9 cycles), Tx_ValidFrame high 25 cycles.
REQ-031 Size 2, data 0xF8,0x03 -> stuffed 0 between bytes: 00011111 0 11000000, no other insertion.
REQ-032 Size 4, Tx_AbortFrame on 3rd bit of byte 1 -> next 8 Tx bits 01111111, Tx_AbortedTrans=1, Tx_ValidFrame=0, total Tx_RdBuff=2.
REQ-033 Tx_Enable with size 0, then size 128 with a second Tx_Enable mid-frame -> first ignored, exactly 128 Tx_RdBuff, second ignored.
REQ-034 Rst asserted mid DATA -> same cycle Tx=1, Tx_ValidFrame=0; no Tx_RdBuff until next Tx_Enable.

Source files
------------

// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared state encoding and framing constants for the HDLC transmitter.
package hdlc_pkg;
   typedef enum logic [2:0] {IDLE, START_FLAG, DATA, END_FLAG, ABORT} state_t;
   localparam logic [7:0] FLAG_BYTE   = 8'h7E;
   localparam logic [7:0] ABORT_BYTE  = 8'hFE;
   localparam logic [2:0] STUFF_LIMIT = 3'd5;
endpackage

// File: rtl/hdlc_tx_stuffer.sv
// hdlc_tx_stuffer: counts consecutive data ones on the line and flags when a zero must be inserted.
module hdlc_tx_stuffer
   import hdlc_pkg::*;
(
   input  logic Clk,
   input  logic Rst,
   input  logic load,
   input  logic bit_in,
   output logic stuff
);
   logic [2:0] ones;
   // Anything other than a data 1 going onto the line (flags, stuffed 0, data 0) restarts the run.
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) ones <= '0;
      else     ones <= (load && bit_in) ? ones + 3'd1 : 3'd0;
   assign stuff = ones == STUFF_LIMIT;
endmodule

// File: rtl/hdlc_tx_ctrl.sv
// hdlc_tx_ctrl: HDLC frame transmitter (flags, zero insertion, abort) driving a registered serial line.
module hdlc_tx_ctrl
   import hdlc_pkg::*;
#(
   parameter int MAX_BYTES = 128
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Tx_Enable,
   input  logic [7:0] Tx_FrameSize,
   input  logic [7:0] Tx_Data,
   input  logic       Tx_AbortFrame,
   output logic       Tx_RdBuff,
   output logic       Tx,
   output logic       Tx_ValidFrame,
   output logic       Tx_AbortedTrans
);
   localparam logic [8:0] MAX_SIZE = 9'(MAX_BYTES);
   state_t     state, state_n;
   logic [2:0] bit_cnt, bit_n, bit_inc;
   logic [7:0] byte_cnt, byte_n, size, size_n, shreg, sh_n;
   logic       stf, stf_n, tx_n, aborted_n, load, bit_in, stuff, last_byte;
   hdlc_tx_stuffer u_stuffer (
      .Clk    (Clk),
      .Rst    (Rst),
      .load   (load),
      .bit_in (bit_in),
      .stuff  (stuff)
   );
   assign bit_inc   = bit_cnt + 3'd1;
   assign last_byte = byte_cnt == size - 8'd1;
   // bit_cnt names the bit currently on Tx; stf marks a stuffed zero, which reuses the previous bit index.
   assign Tx_RdBuff = bit_cnt == 3'd6 &&
                      (state == START_FLAG || (state == DATA && !stf && !last_byte));
   always_comb begin
      state_n   = state;
      bit_n     = bit_cnt;
      byte_n    = byte_cnt;
      size_n    = size;
      sh_n      = shreg;
      stf_n     = 1'b0;
      tx_n      = 1'b1;
      aborted_n = Tx_AbortedTrans;
      load      = 1'b0;
      bit_in    = 1'b0;
      case (state)
         IDLE:
            if (Tx_Enable && Tx_FrameSize != 8'd0 && {1'b0, Tx_FrameSize} <= MAX_SIZE) begin
               state_n   = START_FLAG;
               bit_n     = '0;
               byte_n    = '0;
               size_n    = Tx_FrameSize;
               aborted_n = 1'b0;
               tx_n      = FLAG_BYTE[0];
            end
         START_FLAG:
            if (Tx_AbortFrame) begin
               state_n = ABORT;
               bit_n   = '0;
               tx_n    = ABORT_BYTE[0];
            end else if (bit_cnt == 3'd7) begin
               state_n = DATA;
               bit_n   = '0;
               sh_n    = Tx_Data;
               tx_n    = Tx_Data[0];
               load    = 1'b1;
               bit_in  = Tx_Data[0];
            end else begin
               bit_n = bit_inc;
               tx_n  = FLAG_BYTE[bit_inc];
            end
         DATA:
            if (Tx_AbortFrame) begin
               state_n = ABORT;
               bit_n   = '0;
               tx_n    = ABORT_BYTE[0];
            end else if (stuff) begin
               stf_n = 1'b1;
               tx_n  = 1'b0;
            end else if (bit_cnt == 3'd7 && last_byte) begin
               state_n = END_FLAG;
               bit_n   = '0;
               tx_n    = FLAG_BYTE[0];
            end else if (bit_cnt == 3'd7) begin
               bit_n  = '0;
               byte_n = byte_cnt + 8'd1;
               sh_n   = Tx_Data;
               tx_n   = Tx_Data[0];
               load   = 1'b1;
               bit_in = Tx_Data[0];
            end else begin
               bit_n  = bit_inc;
               tx_n   = shreg[bit_inc];
               load   = 1'b1;
               bit_in = shreg[bit_inc];
            end
         END_FLAG:
            if (bit_cnt == 3'd7) state_n = IDLE;
            else begin
               bit_n = bit_inc;
               tx_n  = FLAG_BYTE[bit_inc];
            end
         ABORT:
            if (bit_cnt == 3'd7) begin
               state_n   = IDLE;
               aborted_n = 1'b1;
            end else begin
               bit_n = bit_inc;
               tx_n  = ABORT_BYTE[bit_inc];
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
         state           <= IDLE;
         bit_cnt         <= '0;
         byte_cnt        <= '0;
         size            <= '0;
         shreg           <= '0;
         stf             <= 1'b0;
         Tx              <= 1'b1;
         Tx_ValidFrame   <= 1'b0;
         Tx_AbortedTrans <= 1'b0;
      end else begin
         state           <= state_n;
         bit_cnt         <= bit_n;
         byte_cnt        <= byte_n;
         size            <= size_n;
         shreg           <= sh_n;
         stf             <= stf_n;
         Tx              <= tx_n;
         Tx_ValidFrame   <= state_n != IDLE;
         Tx_AbortedTrans <= aborted_n;
      end
endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// tb_hdlc_tx_ctrl: randomized and directed frames checked cycle by cycle against a bit-timeline model.
module tb_hdlc_tx_ctrl;
   logic       Clk = 1'b0, Rst, Tx_Enable, Tx_AbortFrame, Tx_RdBuff, Tx, Tx_ValidFrame, Tx_AbortedTrans;
   logic [7:0] Tx_FrameSize, Tx_Data;
   int         vectors = 0, miscompares = 0;
   logic [7:0] payload[$];
   bit         aborted_exp = 1'b0;
   hdlc_tx_ctrl #(.MAX_BYTES(128)) dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Tx_Enable       (Tx_Enable),
      .Tx_FrameSize    (Tx_FrameSize),
      .Tx_Data         (Tx_Data),
      .Tx_AbortFrame   (Tx_AbortFrame),
      .Tx_RdBuff       (Tx_RdBuff),
      .Tx              (Tx),
      .Tx_ValidFrame   (Tx_ValidFrame),
      .Tx_AbortedTrans (Tx_AbortedTrans)
   );
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask
   task automatic idle_check(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         check("idle_tx", Tx, 1);
         check("idle_valid", Tx_ValidFrame, 0);
         check("idle_rd", Tx_RdBuff, 0);
         check("idle_aborted", Tx_AbortedTrans, aborted_exp);
         tick();
      end
   endtask
   task automatic bad_enable(input logic [7:0] sz);
      Tx_FrameSize = sz;
      Tx_Enable    = 1'b1;
      tick();
      Tx_Enable = 1'b0;
      idle_check(2);
   endtask
   // Expected line: flag, payload bits LSB first with a 0 after every run of five data 1s, flag.
   task automatic run_frame(input int abort_pos, input int en_pos, input int rst_pos,
                            input bit abort_with_en, input int req_valid, input int req_pops);
      logic [7:0] flag;
      bit et[$];
      bit er[$];
      int n, ones, data_len, k, pops, vcnt, exp_pops;
      bit ab, rd_now, was_reset;
      flag = 8'h7E;
      n = payload.size();
      for (int i = 0; i < 8; i++) begin et.push_back(flag[i]); er.push_back(i == 6); end
      ones = 0;
      for (int b = 0; b < n; b++)
         for (int i = 0; i < 8; i++) begin
            et.push_back(payload[b][i]);
            er.push_back(i == 6 && b < n - 1);
            ones = payload[b][i] ? ones + 1 : 0;
            if (ones == 5) begin et.push_back(1'b0); er.push_back(1'b0); ones = 0; end
         end
      data_len = et.size() - 8;
      for (int i = 0; i < 8; i++) begin et.push_back(flag[i]); er.push_back(1'b0); end
      ab = abort_pos >= 0 && abort_pos < 8 + data_len;
      if (ab) begin
         while (et.size() > abort_pos + 1) begin void'(et.pop_back()); void'(er.pop_back()); end
         et.push_back(1'b0); er.push_back(1'b0);
         for (int i = 0; i < 7; i++) begin et.push_back(1'b1); er.push_back(1'b0); end
      end
      exp_pops = 0;
      foreach (er[i]) exp_pops += int'(er[i]);
      Tx_FrameSize  = 8'(n);
      Tx_Enable     = 1'b1;
      Tx_AbortFrame = abort_with_en;
      tick();
      Tx_Enable     = 1'b0;
      Tx_AbortFrame = 1'b0;
      aborted_exp   = 1'b0;
      k = 0; pops = 0; vcnt = 0; was_reset = 1'b0;
      for (int p = 0; p < et.size() + 3; p++) begin
         if (p < et.size()) begin
            check("tx", Tx, et[p]);
            check("valid", Tx_ValidFrame, 1);
            check("rd", Tx_RdBuff, er[p]);
            check("aborted", Tx_AbortedTrans, 0);
         end else begin
            check("post_tx", Tx, 1);
            check("post_valid", Tx_ValidFrame, 0);
            check("post_rd", Tx_RdBuff, 0);
            check("post_aborted", Tx_AbortedTrans, ab);
         end
         pops += int'(Tx_RdBuff);
         vcnt += int'(Tx_ValidFrame);
         if (p == rst_pos) begin
            Rst = 1'b1;
            #1;
            check("rst_tx", Tx, 1);
            check("rst_valid", Tx_ValidFrame, 0);
            check("rst_rd", Tx_RdBuff, 0);
            aborted_exp = 1'b0;
            tick();
            Rst = 1'b0;
            idle_check(20);
            was_reset = 1'b1;
            break;
         end
         rd_now        = Tx_RdBuff;
         Tx_AbortFrame = p == abort_pos;
         if (p == en_pos) begin
            Tx_Enable    = 1'b1;
            Tx_FrameSize = 8'($urandom_range(1, 128));
         end
         tick();
         Tx_Enable     = 1'b0;
         Tx_AbortFrame = 1'b0;
         if (rd_now && k < n) Tx_Data = payload[k++];
      end
      if (!was_reset) begin
         aborted_exp = ab;
         check("pops", pops, exp_pops);
         if (req_valid > 0) check("valid_len", vcnt, req_valid);
         if (req_pops >= 0) check("req_pops", pops, req_pops);
      end
   endtask
   initial begin
      Rst = 1'b1; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_FrameSize = '0; Tx_Data = '0;
      #1;
      check("reset_tx", Tx, 1);
      check("reset_valid", Tx_ValidFrame, 0);
      check("reset_rd", Tx_RdBuff, 0);
      check("reset_aborted", Tx_AbortedTrans, 0);
      tick();
      Rst = 1'b0;
      idle_check(2);
      payload = {8'h00};
      run_frame(-1, -1, -1, 1'b0, 24, 1);
      payload = {8'hFF};
      run_frame(-1, -1, -1, 1'b0, 25, 1);
      payload = {8'hF8, 8'h03};
      run_frame(-1, -1, -1, 1'b0, 33, 2);
      payload = {8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(18, -1, -1, 1'b0, 27, 2);
      idle_check(2);
      bad_enable(8'd0);
      bad_enable(8'd129);
      payload = {};
      for (int i = 0; i < 128; i++) payload.push_back(8'($urandom));
      run_frame(-1, 500, -1, 1'b0, 0, 128);
      payload = {8'hFF, 8'h00, 8'hAA};
      run_frame(-1, -1, 13, 1'b0, 0, -1);
      payload = {8'h3C, 8'hFF};
      run_frame(-1, -1, -1, 1'b1, 0, 2);
      for (int f = 0; f < 30; f++) begin
         int n, mode;
         n = $urandom_range(1, 12);
         payload = {};
         for (int i = 0; i < n; i++) payload.push_back($urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom));
         mode = $urandom_range(0, 5);
         run_frame(mode < 2 ? int'($urandom_range(0, 8 * n + 30)) : -1,
                   mode == 2 ? int'($urandom_range(1, 8 * n + 8)) : -1,
                   mode == 3 ? int'($urandom_range(9, 8 * n + 8)) : -1,
                   1'($urandom_range(0, 1)), 0, -1);
         if ($urandom_range(0, 3) == 0) bad_enable($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(129, 255)));
         idle_check($urandom_range(0, 3));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
